banner_column_reader: RTL and testbench
=======================================

// Module: banner_column_reader
// PURPOSE
//  Reader/sequencer for the banner column ROMs (57-bit column per address, address registered inside ROM).
//  Walks ROM addresses 0..DEPTH-1, absorbs the ROM's one-cycle address-register latency, and presents
//  each column to the LED matrix driver for one step period. Sits between the scroll-rate divider and the matrix driver.
// PARAMETERS
//  DEPTH   129  number of valid ROM columns (addresses 0..DEPTH-1)
//  WIDTH   57   column width in bits (ROM data width)
//  ADDR_W  8    ROM address width; DEPTH <= 2**ADDR_W
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  start      in   1       begin playback from column 0 (sampled in IDLE only)
//  stop       in   1       abort playback; return to IDLE
//  step_tick  in   1       one-cycle advance strobe from scroll-rate divider
//  rom_addr   out  ADDR_W  address to banner ROM
//  rom_data   in   WIDTH   column data from banner ROM (valid 1 cycle after rom_addr)
//  col_data   out  WIDTH   column currently displayed (registered)
//  col_index  out  ADDR_W  address of col_data
//  col_valid  out  1       one-cycle pulse when col_data/col_index update
//  busy       out  1       high in any state except IDLE
//  done       out  1       one-cycle pulse after last column's hold period ends
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, rom_addr=0, col_data=0, col_index=0, col_valid=0, busy=0, done=0.
//  States: IDLE -> FETCH -> CAPTURE -> HOLD -> (FETCH | IDLE).
//   IDLE:    rom_addr=0. start=1 -> FETCH with ptr=0.
//   FETCH:   rom_addr=ptr presented this cycle (ROM registers it at edge) -> CAPTURE unconditionally.
//   CAPTURE: rom_data valid; col_data<=rom_data, col_index<=ptr, col_valid pulses 1 cycle after -> HOLD.
//   HOLD:    rom_addr held at ptr. On step_tick: ptr<DEPTH-1 -> ptr+1, FETCH;
//            ptr==DEPTH-1 -> end-of-banner (see CONFIGURATION).
//  Latency: start to first col_valid = 3 cycles (IDLE edge, FETCH, CAPTURE); step_tick to next col_valid = 3 cycles.
//  step_tick outside HOLD is ignored (not queued); step_tick every cycle yields one column per 3 cycles max.
//  stop has priority over start and step_tick in every non-IDLE state: next state IDLE, ptr=0; col_data/col_index retain
//   last value; done NOT pulsed; in-flight CAPTURE discarded (no col_valid).
//  start while busy: ignored. start and stop same cycle in IDLE: stays IDLE.
//  ptr arithmetic: unsigned ADDR_W bits; never exceeds DEPTH-1; compare uses DEPTH-1 sized to ADDR_W.
//  busy combinational from state (0 only in IDLE); done/col_valid registered pulses.
//  rst mid-playback: all outputs return to reset values next edge, no done pulse.
// CONFIGURATION
//  BANNER_LOOP_EN defined: at end-of-banner done pulses 1 cycle, ptr wraps to 0, state -> FETCH;
//   playback repeats until stop or rst; busy stays 1 across the wrap.
//  BANNER_LOOP_EN undefined: at end-of-banner done pulses 1 cycle, state -> IDLE, busy falls same edge,
//   col_data/col_index keep last column (DEPTH-1) until next start.
// TESTING
//  Reset: rst high 2 cycles mid-HOLD -> all outputs 0, state IDLE, busy=0 next cycle.
//  Latency: start pulse at cycle 0 -> rom_addr=0 in FETCH, col_valid at cycle 3 with col_index=0,
//   col_data=ROM[0] (57'b111 followed by 54 zeros).
//  Full sweep: step_tick every 10 cycles -> 129 col_valid pulses, col_index 0..128 in order, each col_data==ROM model.
//  End (loop off): after index 128 hold + step_tick -> done=1 one cycle, busy=0, col_index stays 128.
//  End (BANNER_LOOP_EN): same stimulus -> done pulse, next col_valid has col_index=0, busy stays 1.
//  Stop: stop asserted in CAPTURE at index 57 -> no col_valid, IDLE next cycle, col_index stays 56, no done.

Source files
------------

// File: rtl/banner_column_reader.sv
// Banner column ROM reader: walks ROM addresses 0..DEPTH-1 and presents each column for one step period.
// Optional feature: define BANNER_LOOP_EN to replay the banner from column 0 instead of stopping at the end.
module banner_column_reader #(
  parameter int DEPTH  = 129,
  parameter int WIDTH  = 57,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic [WIDTH-1:0]  col_data,
  output logic [ADDR_W-1:0] col_index,
  output logic              col_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_col_data;
  logic [ADDR_W-1:0] r_col_index;
  logic              r_col_valid;
  logic              r_done;

  logic              w_at_last;
  logic              w_capture;
  logic              w_step;
  logic              w_end;
  logic              w_abort;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start && !stop) w_next = S_FETCH;
      S_FETCH:   w_next = stop ? S_IDLE : S_CAPTURE;
      S_CAPTURE: w_next = stop ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (step_tick) begin
          if (!w_at_last) begin
            w_next = S_FETCH;
          end else begin
`ifdef BANNER_LOOP_EN
            w_next = S_FETCH;
`else
            w_next = S_IDLE;
`endif
          end
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    rom_addr  = (r_state == S_IDLE) ? '0 : r_ptr;
    w_at_last = (r_ptr == LAST_IDX);
    w_abort   = busy && stop;
    w_capture = (r_state == S_CAPTURE) && !stop;
    w_step    = (r_state == S_HOLD) && step_tick && !stop;
    w_end     = w_step && w_at_last;
  end

  // Column registers survive stop and end-of-banner; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_col_data  <= '0;
      r_col_index <= '0;
      r_col_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_col_valid <= w_capture;
      r_done      <= w_end;
      if (w_capture) begin
        r_col_data  <= rom_data;
        r_col_index <= r_ptr;
      end
      if (w_abort || (r_state == S_IDLE)) begin
        r_ptr <= '0;
      end else if (w_step) begin
        r_ptr <= w_at_last ? '0 : r_ptr + ADDR_W'(1);
      end
    end
  end

  assign col_data  = r_col_data;
  assign col_index = r_col_index;
  assign col_valid = r_col_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_banner_column_reader.sv
// Self-checking bench for banner_column_reader: random-gap playback against a column-sequence model,
// with a scoreboard monitor consuming every col_valid and done pulse.
module tb_banner_column_reader;

  localparam int DEPTH  = 129;
  localparam int WIDTH  = 57;
  localparam int ADDR_W = 8;
`ifdef BANNER_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, start, stop, step_tick;
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic [WIDTH-1:0]  col_data;
  logic [ADDR_W-1:0] col_index;
  logic              col_valid, busy, done;

  logic [WIDTH-1:0]  rom_mem [2**ADDR_W];

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int done_pending = 0;
  int m_ptr = 0;
  bit m_playing = 0;

  banner_column_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step_tick(step_tick),
    .rom_addr(rom_addr), .rom_data(rom_data), .col_data(col_data),
    .col_index(col_index), .col_valid(col_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Banner ROM with registered address: data follows the address by one edge.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented column must match the next expected index and ROM contents.
  always @(negedge clk) begin
    if (col_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_col_valid", 64'(col_valid), 64'd0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("col_index", 64'(col_index), 64'(e));
        check("col_data", 64'(col_data), 64'(rom_mem[e]));
      end
    end
    if (done === 1'b1) begin
      if (done_pending == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        done_pending--;
        check("busy_at_done", 64'(busy), 64'(LOOP));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_start();
    start = 1'b1;
    if (!m_playing) begin
      m_playing = 1;
      m_ptr = 0;
      exp_q.push_back(0);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model of one accepted step: next column, or end-of-banner.
  task automatic model_step();
    if (m_ptr < DEPTH - 1) begin
      m_ptr++;
      exp_q.push_back(m_ptr);
    end else begin
      done_pending++;
      m_ptr = 0;
      if (LOOP) exp_q.push_back(0);
      else m_playing = 0;
    end
  endtask

  task automatic issue_tick();
    step_tick = 1'b1;
    model_step();
    @(negedge clk);
    step_tick = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 60;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_q.delete();
    done_pending = 0;
    m_playing = 0;
    m_ptr = 0;
  endtask

  initial begin
    for (int a = 0; a < 2**ADDR_W; a++) rom_mem[a] = {$urandom, $urandom};
    rom_mem[0] = {3'b111, 54'd0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; step_tick = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_col_data", 64'(col_data), 64'd0);
    check("rst_col_index", 64'(col_index), 64'd0);
    check("rst_col_valid", 64'(col_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // First-column latency: valid exactly three edges after start.
    issue_start();
    check("fetch_busy", 64'(busy), 64'd1);
    check("fetch_rom_addr", 64'(rom_addr), 64'd0);
    check("fetch_no_valid", 64'(col_valid), 64'd0);
    cyc(1);
    check("capture_no_valid", 64'(col_valid), 64'd0);
    cyc(1);
    check("lat3_col_valid", 64'(col_valid), 64'd1);
    check("lat3_col_data", 64'(col_data), 64'(rom_mem[0]));

    // Full sweep with random step spacing (always landing in HOLD).
    for (int i = 1; i < DEPTH; i++) begin
      cyc($urandom_range(2, 11));
      issue_tick();
    end
    drain("sweep");
    cyc(2);
    check("hold_addr_last", 64'(rom_addr), 64'(DEPTH - 1));
    issue_tick();
    check("end_done", 64'(done), 64'd1);
    check("end_busy", 64'(busy), 64'(LOOP));
    check("end_col_index", 64'(col_index), 64'(DEPTH - 1));
    cyc(1);
    check("end_done_one_cycle", 64'(done), 64'd0);
    drain("end");
    stop = 1'b1; cyc(1); stop = 1'b0;
    m_playing = 0;
    check("post_end_idle", 64'(busy), 64'd0);

    // Stop while column 57 is being captured.
    issue_start();
    cyc(2);
    for (int i = 1; i <= 56; i++) begin
      issue_tick();
      cyc(2);
    end
    drain("to56");
    step_tick = 1'b1; cyc(1); step_tick = 1'b0;
    check("fetch57_addr", 64'(rom_addr), 64'd57);
    cyc(1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    m_playing = 0;
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_no_valid", 64'(col_valid), 64'd0);
    check("stop_col_index", 64'(col_index), 64'd56);
    check("stop_no_done", 64'(done), 64'd0);
    check("stop_rom_addr", 64'(rom_addr), 64'd0);
    cyc(5);

    // start together with stop in IDLE is ignored.
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 64'(busy), 64'd0);
    cyc(3);
    check("start_stop_no_valid_later", 64'(busy), 64'd0);

    // Continuous step_tick: at most one column per three cycles; start while busy ignored.
    issue_start();
    drain("burst_start");
    step_tick = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) model_step();
      cyc(1);
    end
    step_tick = 1'b0;
    start = 1'b0;
    drain("burst");
    cyc(1);
    check("burst_col_index", 64'(col_index), 64'd3);
    check("burst_busy", 64'(busy), 64'd1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    m_playing = 0;
    check("stop_in_hold", 64'(busy), 64'd0);
    check("stop_hold_index", 64'(col_index), 64'd3);

    // Reset mid-HOLD returns everything to reset values.
    issue_start();
    cyc(2);
    issue_tick();
    drain("pre_reset");
    cyc(1);
    step_tick = 1'b1;
    do_reset();
    step_tick = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_col_data", 64'(col_data), 64'd0);
    check("mid_rst_col_index", 64'(col_index), 64'd0);
    check("mid_rst_rom_addr", 64'(rom_addr), 64'd0);
    check("mid_rst_valid", 64'(col_valid), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    cyc(4);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_done_pending", 64'(done_pending), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
